mmio_timer_responder: RTL and testbench
=======================================

Name: mmio_timer_responder

Overview:
Memory-mapped timer peripheral, the responder end of the processor's data-port handshake (ReadData/WriteData/DataAddr/DataOut -> DataIn/DataDone). Instantiated inside avalon_bus alongside other responders; its DataIn/DataDone outputs are OR-combined there. Provides a prescaled 16-bit down-counter with auto-reload, a sticky expiry flag and an interrupt line.

Parameters:
BASE_ADDR, 16'hFF40, word address of the 8-word register window; must be 8-aligned, so bits [2:0] are ignored.
WAIT_CYCLES, 1, extra cycles between request sampling and DataDone; range 0..15.
PRESCALE, 50000, Clock cycles per counter tick; values below 1 are treated as 1.
PS_WIDTH, 16, width of the prescaler counter; must satisfy 2^PS_WIDTH >= PRESCALE.

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
ReadData  in  1  read request strobe from processor
WriteData  in  1  write request strobe from processor
DataAddr  in  16  word address of the access
DataOut  in  16  write data from processor
DataIn  out  16  read data to processor; non-zero only while DataDone=1
DataDone  out  1  one-cycle completion pulse
Irq  out  1  interrupt request, level-sensitive
CaptureIn  in  1  capture strobe; present only with TIMER_CAPTURE_EN

Behaviour:
- Reset is asynchronous and active-high. It clears the FSM to IDLE and sets DataIn=0, DataDone=0, Irq=0, CTRL=0, LOAD=16'hFFFF, COUNT=16'hFFFF, STATUS=0, prescaler=0.
- Select: sel = (ReadData|WriteData) && DataAddr[15:3]==BASE_ADDR[15:3]. Offset = DataAddr[2:0].
- When not selected, the block produces no DataDone and holds DataIn=0.
- FSM states IDLE, WAIT, DONE:
  - IDLE: sample sel. If set, latch offset, R/W and DataOut. Go to WAIT if WAIT_CYCLES>0, else DONE.
  - WAIT: count WAIT_CYCLES cycles, then go to DONE. Request strobes are ignored.
  - DONE: DataDone=1 for exactly one cycle. DataIn carries read data (0 for writes). A write takes effect at the end of this cycle. Always returns to IDLE.
- Latency from request to DataDone is WAIT_CYCLES+1 cycles.
- The requester deasserts or replaces its strobe in the cycle after DataDone. A strobe still high in IDLE starts a new access.
- ReadData and WriteData both high: treated as a write; DataIn=0.
- Register map by offset:
  - 0 CTRL[2:0], read/write: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; upper bits read 0.
  - 1 LOAD, read/write. A write while EN=0 also copies the value into COUNT and clears the prescaler.
  - 2 COUNT, read-only; writes are ignored but still complete.
  - 3 STATUS[0] EXPIRED: write 1 to clear, write 0 has no effect.
  - 4-7 read 0, writes are ignored; both complete normally.
- Writing CTRL with EN 0->1 clears the prescaler.
- Counting: while EN=1 the prescaler increments each cycle. At PRESCALE-1 it wraps to 0 and issues a tick. On a tick:
  - If COUNT!=0: COUNT decrements by 1.
  - If COUNT==0: EXPIRED is set. With AUTO_RELOAD, COUNT=LOAD; otherwise EN is cleared and COUNT stays 0.
- Simultaneous events:
  - Expiry and a STATUS clear in the same cycle: set wins.
  - CTRL write and a tick in the same cycle: the tick uses the old CTRL, then the write applies.
  - LOAD write during counting: COUNT is not affected until the next reload.
- Irq = EXPIRED & IRQ_EN, registered, so it follows those bits by one cycle.
- Reset asserted mid-access aborts the access; no DataDone is issued.

Optional Feature:
TIMER_CAPTURE_EN:
- Defined: adds the CaptureIn port. A 2-flop synchroniser and rising-edge detect copy COUNT into CAPTURE (offset 4, read-only, reset 0) and set STATUS[1] CAP_FLAG (write 1 to clear; set wins on conflict). Irq = (EXPIRED|CAP_FLAG) & IRQ_EN.
- Undefined: the port is absent, offset 4 reads 0 and STATUS[1] reads 0.

Test Plan:
- Reset, then read offsets 0..3 at FF40..FF43 -> 0000, FFFF, FFFF, 0000. DataDone arrives exactly 2 cycles after ReadData (WAIT_CYCLES=1).
- Read FF48 (outside window) -> DataDone never asserts within 20 cycles; DataIn stays 0.
- PRESCALE=4: write LOAD=3, then CTRL=3'b011 -> COUNT reads 3,2,1,0 at 4-cycle steps. The next tick sets EXPIRED and COUNT reloads to 3; Irq stays 0.
- Same setup with CTRL=3'b100 plus EN and no AUTO_RELOAD -> at expiry EN clears, COUNT holds 0, Irq rises. Write STATUS=1 -> Irq falls one cycle after DataDone.
- Write STATUS=1 in the same cycle as an expiry tick -> EXPIRED reads 1 afterward.
- With TIMER_CAPTURE_EN: pulse CaptureIn when COUNT=2 -> offset 4 reads 0002 and STATUS reads 0002. Assert Reset during WAIT -> no DataDone, all registers back at their reset values.

Source files
------------

// File: rtl/mmio_timer_responder.sv
// rtl/mmio_timer_responder.sv - memory-mapped prescaled down-counter timer responder, optional capture via TIMER_CAPTURE_EN
module mmio_timer_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF40,
    parameter int          WAIT_CYCLES = 1,
    parameter int          PRESCALE    = 50000,
    parameter int          PS_WIDTH    = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReadData,
    input  logic        WriteData,
    input  logic [15:0] DataAddr,
    input  logic [15:0] DataOut,
    output logic [15:0] DataIn,
    output logic        DataDone,
`ifdef TIMER_CAPTURE_EN
    input  logic        CaptureIn,
`endif
    output logic        Irq
);

    localparam int                  PS_EFF    = (PRESCALE < 1) ? 1 : PRESCALE;
    localparam logic [PS_WIDTH-1:0] PS_LAST   = PS_WIDTH'(PS_EFF - 1);
    localparam logic [3:0]          WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic                HAS_WAIT  = (WAIT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          wait_cnt;
    logic [2:0]          req_off;
    logic                req_wr;
    logic [15:0]         req_data;
    logic                sel;

    logic [2:0]          ctrl;
    logic [15:0]         load_reg;
    logic [15:0]         count;
    logic                expired;
    logic [PS_WIDTH-1:0] prescaler;
    logic                cap_flag;
    logic [15:0]         capture;
    logic [15:0]         rd_data;

    logic                wr_en;
    logic                wr_ctrl;
    logic                wr_load;
    logic                wr_status;
    logic                tick;
    logic                expire;

    // Bits [2:0] of the base are ignored so the window is always 8-aligned.
    assign sel = (ReadData | WriteData) && (DataAddr[15:3] == BASE_ADDR[15:3]);

    // Write side-effects land on the clock edge that ends the DONE cycle.
    assign wr_en     = (state == ST_DONE) && req_wr;
    assign wr_ctrl   = wr_en && (req_off == 3'd0);
    assign wr_load   = wr_en && (req_off == 3'd1);
    assign wr_status = wr_en && (req_off == 3'd3);

    assign tick   = ctrl[0] && (prescaler == PS_LAST);
    assign expire = tick && (count == 16'd0);

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the request in IDLE and count wait cycles; both-strobes counts as a write.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            req_off  <= 3'd0;
            req_wr   <= 1'b0;
            req_data <= 16'd0;
            wait_cnt <= 4'd0;
        end else begin
            if (state == ST_IDLE && sel) begin
                req_off  <= DataAddr[2:0];
                req_wr   <= WriteData;
                req_data <= DataOut;
            end
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
        end
    end

    // Next-state and handshake outputs; DataIn is forced to zero outside a read completion.
    always_comb begin
        state_next = state;
        DataDone   = 1'b0;
        DataIn     = 16'd0;
        case (state)
            ST_IDLE: begin
                if (sel) begin
                    state_next = HAS_WAIT ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                DataDone   = 1'b1;
                DataIn     = req_wr ? 16'd0 : rd_data;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Register read mux on the latched offset.
    always_comb begin
        rd_data = 16'd0;
        case (req_off)
            3'd0:    rd_data = {13'd0, ctrl};
            3'd1:    rd_data = load_reg;
            3'd2:    rd_data = count;
            3'd3:    rd_data = {14'd0, cap_flag, expired};
            3'd4:    rd_data = capture;
            default: rd_data = 16'd0;
        endcase
    end

    // Timer core: the tick acts on the old CTRL first, then bus writes override; expiry beats a clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ctrl      <= 3'd0;
            load_reg  <= 16'hFFFF;
            count     <= 16'hFFFF;
            expired   <= 1'b0;
            prescaler <= '0;
        end else begin
            if (ctrl[0]) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
            end
            if (tick) begin
                if (count != 16'd0) begin
                    count <= count - 16'd1;
                end else if (ctrl[1]) begin
                    count <= load_reg;
                end else begin
                    ctrl[0] <= 1'b0;
                end
            end
            if (wr_ctrl) begin
                ctrl <= req_data[2:0];
                if (!ctrl[0] && req_data[0]) begin
                    prescaler <= '0;
                end
            end
            if (wr_load) begin
                load_reg <= req_data;
                if (!ctrl[0]) begin
                    count     <= req_data;
                    prescaler <= '0;
                end
            end
            if (wr_status && req_data[0]) begin
                expired <= 1'b0;
            end
            if (expire) begin
                expired <= 1'b1;
            end
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic cap_s1;
    logic cap_s2;
    logic cap_s3;
    logic cap_rise;

    assign cap_rise = cap_s2 && !cap_s3;

    // Synchronise CaptureIn, snapshot COUNT on its rising edge; a new capture beats a clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cap_s1   <= 1'b0;
            cap_s2   <= 1'b0;
            cap_s3   <= 1'b0;
            capture  <= 16'd0;
            cap_flag <= 1'b0;
        end else begin
            cap_s1 <= CaptureIn;
            cap_s2 <= cap_s1;
            cap_s3 <= cap_s2;
            if (wr_status && req_data[1]) begin
                cap_flag <= 1'b0;
            end
            if (cap_rise) begin
                capture  <= count;
                cap_flag <= 1'b1;
            end
        end
    end
`else
    assign capture  = 16'd0;
    assign cap_flag = 1'b0;
`endif

    // Interrupt is registered, so it trails the status and enable bits by one cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Irq <= 1'b0;
        end else begin
            Irq <= (expired | cap_flag) & ctrl[2];
        end
    end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// tb/tb_mmio_timer_responder.sv - scoreboard bench for mmio_timer_responder
module tb_mmio_timer_responder;

    localparam int WAIT_CYCLES = 1;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ReadData = 1'b0;
    logic        WriteData = 1'b0;
    logic [15:0] DataAddr = 16'd0;
    logic [15:0] DataOut = 16'd0;
    logic [15:0] DataIn;
    logic        DataDone;
    logic        Irq;
`ifdef TIMER_CAPTURE_EN
    logic        CaptureIn = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    mmio_timer_responder #(
        .BASE_ADDR  (16'hFF40),
        .WAIT_CYCLES(WAIT_CYCLES),
        .PRESCALE   (4),
        .PS_WIDTH   (16)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .ReadData (ReadData),
        .WriteData(WriteData),
        .DataAddr (DataAddr),
        .DataOut  (DataOut),
        .DataIn   (DataIn),
        .DataDone (DataDone),
`ifdef TIMER_CAPTURE_EN
        .CaptureIn(CaptureIn),
`endif
        .Irq      (Irq)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every DataDone pops one expected response.
    always @(negedge Clock) begin
        if (DataDone === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got DataDone=1 DataIn=%h expected no completion", DataIn);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, DataIn, e.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge two cycles after DataDone's cycle start.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] wdata, input logic [15:0] exp);
        int lat;
        exp_q.push_back('{exp, name});
        ReadData  = rd;
        WriteData = wr;
        DataAddr  = addr;
        DataOut   = wdata;
        @(posedge Clock);
        @(negedge Clock);
        ReadData  = 1'b0;
        WriteData = 1'b0;
        lat = 1;
        while (DataDone !== 1'b1 && lat < 20) begin
            @(negedge Clock);
            lat++;
        end
        check({name, "_latency"}, 16'(lat), 16'(WAIT_CYCLES + 1));
        if (DataDone !== 1'b1) begin
            void'(exp_q.pop_back());
        end
        @(negedge Clock);
    endtask

    task automatic rd(input string name, input logic [15:0] addr, input logic [15:0] exp);
        access(name, 1'b1, 1'b0, addr, 16'd0, exp);
    endtask

    task automatic wr(input string name, input logic [15:0] addr, input logic [15:0] data);
        access(name, 1'b0, 1'b1, addr, data, 16'd0);
    endtask

    initial begin
        int bad;

        // Reset state
        repeat (2) @(negedge Clock);
        check("rst_done", {15'd0, DataDone}, 16'd0);
        check("rst_datain", DataIn, 16'd0);
        check("rst_irq", {15'd0, Irq}, 16'd0);
        Reset = 1'b0;
        @(negedge Clock);
        rd("rst_ctrl",   16'hFF40, 16'h0000);
        rd("rst_load",   16'hFF41, 16'hFFFF);
        rd("rst_count",  16'hFF42, 16'hFFFF);
        rd("rst_status", 16'hFF43, 16'h0000);

        // Outside the window: no completion, DataIn quiet
        ReadData = 1'b1;
        DataAddr = 16'hFF48;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (DataDone !== 1'b0 || DataIn !== 16'd0) bad++;
        end
        ReadData = 1'b0;
        check("out_of_window_quiet", 16'(bad), 16'd0);
        @(negedge Clock);

        // Register map corners
        access("both_strobes_write", 1'b1, 1'b1, 16'hFF41, 16'h1234, 16'h0000);
        rd("load_1234",  16'hFF41, 16'h1234);
        rd("count_1234", 16'hFF42, 16'h1234);
        wr("count_wr_ignored", 16'hFF42, 16'h5555);
        rd("count_still_1234", 16'hFF42, 16'h1234);
        rd("off4_zero", 16'hFF44, 16'h0000);
        wr("off7_wr", 16'hFF47, 16'hABCD);
        rd("off7_zero", 16'hFF47, 16'h0000);
        wr("ctrl_upper", 16'hFF40, 16'hFFF8);
        rd("ctrl_upper_zero", 16'hFF40, 16'h0000);

        // Auto-reload countdown, no IRQ enable
        wr("ar_load", 16'hFF41, 16'h0003);
        wr("ar_ctrl", 16'hFF40, 16'h0003);
        rd("ar_count3", 16'hFF42, 16'h0003); @(negedge Clock);
        rd("ar_count2", 16'hFF42, 16'h0002); @(negedge Clock);
        rd("ar_count1", 16'hFF42, 16'h0001); @(negedge Clock);
        rd("ar_count0", 16'hFF42, 16'h0000); @(negedge Clock);
        rd("ar_reload", 16'hFF42, 16'h0003); @(negedge Clock);
        rd("ar_expired", 16'hFF43, 16'h0001);
        check("ar_irq_low", {15'd0, Irq}, 16'd0);

        // One-shot with IRQ enable
        wr("os_stop", 16'hFF40, 16'h0000);
        wr("os_clr", 16'hFF43, 16'h0001);
        wr("os_load", 16'hFF41, 16'h0003);
        wr("os_ctrl", 16'hFF40, 16'h0005);
        rd("os_count3", 16'hFF42, 16'h0003); @(negedge Clock);
        rd("os_count2", 16'hFF42, 16'h0002); @(negedge Clock);
        rd("os_count1", 16'hFF42, 16'h0001); @(negedge Clock);
        rd("os_count0", 16'hFF42, 16'h0000); @(negedge Clock);
        rd("os_hold0",  16'hFF42, 16'h0000); @(negedge Clock);
        rd("os_en_cleared", 16'hFF40, 16'h0004);
        rd("os_expired", 16'hFF43, 16'h0001);
        check("os_irq_high", {15'd0, Irq}, 16'd1);
        wr("os_status_clr", 16'hFF43, 16'h0001);
        check("os_irq_still_high", {15'd0, Irq}, 16'd1);
        @(negedge Clock);
        check("os_irq_fell", {15'd0, Irq}, 16'd0);

        // STATUS clear on the same edge as an expiry tick
        wr("sim_load", 16'hFF41, 16'h0003);
        wr("sim_ctrl", 16'hFF40, 16'h0003);
        repeat (13) @(negedge Clock);
        wr("sim_clr", 16'hFF43, 16'h0001);
        rd("sim_set_wins", 16'hFF43, 16'h0001);

`ifdef TIMER_CAPTURE_EN
        // Capture at COUNT=2
        wr("cap_stop", 16'hFF40, 16'h0000);
        wr("cap_clr", 16'hFF43, 16'h0003);
        wr("cap_load", 16'hFF41, 16'h0003);
        wr("cap_ctrl", 16'hFF40, 16'h0003);
        repeat (3) @(negedge Clock);
        CaptureIn = 1'b1;
        repeat (2) @(negedge Clock);
        CaptureIn = 1'b0;
        rd("cap_value", 16'hFF44, 16'h0002);
        rd("cap_status", 16'hFF43, 16'h0002);
`endif

        // Reset during WAIT aborts the access
        ReadData = 1'b1;
        DataAddr = 16'hFF41;
        @(posedge Clock);
        @(negedge Clock);
        ReadData = 1'b0;
        Reset = 1'b1;
        check("abort_done_in_reset", {15'd0, DataDone}, 16'd0);
        @(negedge Clock);
        Reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            if (DataDone !== 1'b0) bad++;
        end
        check("abort_no_done", 16'(bad), 16'd0);
        rd("abort_ctrl",   16'hFF40, 16'h0000);
        rd("abort_load",   16'hFF41, 16'hFFFF);
        rd("abort_count",  16'hFF42, 16'hFFFF);
        rd("abort_status", 16'hFF43, 16'h0000);
        rd("abort_off4",   16'hFF44, 16'h0000);
        check("abort_irq", {15'd0, Irq}, 16'd0);

        repeat (2) @(negedge Clock);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
